csr_trap_ctrl: RTL
==================

// Module: csr_trap_ctrl
// PURPOSE
// - Sequences the machine CSR file for external-interrupt entry and MRET return.
// - Arbitrates the single CSR access port between pipeline CSR instructions and its own trap FSM.
// - On entry: saves the PC to mepc, writes mcause, updates mstatus, reads mtvec, then redirects and flushes the pipeline.
// - Sits between the decode/execute stage and the CSR register file.
// PARAMETERS
// - DW        32            data width
// - ADDRW     12            CSR address width
// - CAUSE_EXT 32'h8000_000B mcause value for an M-mode external interrupt
// - Fixed CSR addresses: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342
// PORTS
// - clk_i          in   1      clock
// - rst_i          in   1      reset, asynchronous, active-high
// - intr_i         in   1      external interrupt request, level
// - mret_i         in   1      MRET retiring this cycle, 1-cycle pulse
// - pc_i           in   DW     PC to save on interrupt entry
// - pipe_we_i      in   1      pipeline CSR write request
// - pipe_re_i      in   1      pipeline CSR read request
// - pipe_addr_i    in   ADDRW  pipeline CSR address
// - pipe_wdata_i   in   DW     pipeline CSR write data
// - pipe_rdata_o   out  DW     CSR read data returned to the pipeline
// - stall_o        out  1      pipeline CSR access not granted this cycle
// - csr_we_o       out  1      CSR file write enable
// - csr_re_o       out  1      CSR file read enable
// - csr_addr_o     out  ADDRW  CSR file address
// - csr_wdata_o    out  DW     CSR file write data
// - csr_rdata_i    in   DW     CSR file read data (combinational)
// - redirect_o     out  1      PC redirect, 1-cycle pulse
// - target_o       out  DW     redirect target, valid while redirect_o is high
// - flush_o        out  1      pipeline flush, asserted together with redirect_o
// BEHAVIOUR
// - Reset: FSM goes to IDLE. Every output and every internal register goes to 0.
//   - A reset mid-sequence abandons the sequence. CSRs already written keep their values.
// - Shadows: mie_q = mstatus[3], mpie_q = mstatus[7], meie_q = mie[11].
//   - Updated on every csr_we_o to mstatus or mie, whether from the pipeline or from the FSM.
// - IDLE, no trap starting: pipeline port passes straight through to the CSR port.
//   - stall_o = 0; pipe_rdata_o = csr_rdata_i.
// - Trap start in IDLE:
//   - mret_i takes priority over an interrupt.
//   - An interrupt is taken when intr_i & mie_q & meie_q.
//   - In the accept cycle T: pc_i is latched, the pipeline request is blocked (stall_o = pipe_we_i|pipe_re_i), and the CSR port is idle.
// - Outside IDLE: stall_o = pipe_we_i|pipe_re_i and pipe_rdata_o = 0. The pipeline retries its access after the FSM returns to IDLE.
// - Entry sequence (one state per cycle):
//   - T+1 E_RD_ST: read mstatus, latch the word.
//   - T+2 E_WR_EPC: write mepc with the latched PC.
//   - T+3 E_WR_CAUSE: write mcause with CAUSE_EXT.
//   - T+4 E_WR_ST: write mstatus with MPIE = old MIE, MIE = 0, other bits unchanged.
//   - T+5 E_RD_TVEC: read mtvec, compute the target.
//   - T+6 REDIR: redirect_o = flush_o = 1, target_o = registered target.
//   - T+7 IDLE.
// - MRET sequence:
//   - T+1 M_RD_ST: read mstatus.
//   - T+2 M_WR_ST: write mstatus with MIE = MPIE, MPIE = 1.
//   - T+3 M_RD_EPC: target = mepc & ~3.
//   - T+4 REDIR.
//   - T+5 IDLE.
// - Target: base = mtvec & ~32'h3.
// - Outside REDIR, redirect_o, flush_o and target_o are 0.
// - mret_i or intr_i arriving during a sequence is ignored. intr_i is level and is re-evaluated in IDLE.
// - A re-trap after entry is blocked until MRET because E_WR_ST clears MIE.
// CONFIGURATION
// - VECTORED_INTR_EN defined: if mtvec[1:0] == 2'b01, target = base + 4*CAUSE_EXT[4:0] (external interrupt: base + 44). Otherwise target = base.
// - VECTORED_INTR_EN undefined: target = base always. mtvec[1:0] is ignored.
// TESTING
// - mstatus = 0, intr_i held high -> no redirect, pipeline CSR accesses are never stalled.
// - mtvec = 0x100, mie = 0x800, mstatus = 0x8, pc_i = 0x44, intr_i = 1 ->
//   - mepc = 0x44, mcause = 0x8000000B, mstatus = 0x80;
//   - redirect_o/flush_o high at T+6 with target_o = 0x100.
// - After the previous test, mret_i pulse -> mstatus = 0x88; redirect at T+4 with target_o = 0x44.
// - Pipeline write of mie = 0 during the entry sequence -> stall_o high until IDLE, then the write lands.
// - mret_i and a takeable intr_i in the same cycle -> MRET sequence first; interrupt entered afterwards once MIE is restored.
// - rst_i asserted in E_WR_CAUSE -> FSM in IDLE, all outputs 0, mcause unchanged.
// - VECTORED_INTR_EN defined, mtvec = 0x101 -> target_o = 0x12C.

Source files
------------

// File: rtl/csr_trap_ctrl_if.sv
// csr_trap_ctrl_if
//   Bundles the two CSR access buses that meet at csr_trap_ctrl:
//     pipe_* : CSR requests from decode/execute and the data and stall returned to it
//     csr_*  : the single access port into the machine CSR register file
//   slave  modport : used by csr_trap_ctrl (accepts pipe requests, drives the CSR port)
//   master modport : used by the environment (pipeline and CSR file side)
interface csr_trap_ctrl_if #(
    parameter int DW    = 32,
    parameter int ADDRW = 12
);
    logic             pipe_we;
    logic             pipe_re;
    logic [ADDRW-1:0] pipe_addr;
    logic [DW-1:0]    pipe_wdata;
    logic [DW-1:0]    pipe_rdata;
    logic             stall;

    logic             csr_we;
    logic             csr_re;
    logic [ADDRW-1:0] csr_addr;
    logic [DW-1:0]    csr_wdata;
    logic [DW-1:0]    csr_rdata;

    modport slave (
        input  pipe_we, pipe_re, pipe_addr, pipe_wdata, csr_rdata,
        output pipe_rdata, stall, csr_we, csr_re, csr_addr, csr_wdata
    );

    modport master (
        output pipe_we, pipe_re, pipe_addr, pipe_wdata, csr_rdata,
        input  pipe_rdata, stall, csr_we, csr_re, csr_addr, csr_wdata
    );
endinterface

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl
//   Sequences the machine CSR file for external-interrupt entry and MRET
//   return, and arbitrates the single CSR port between pipeline CSR
//   instructions and its own trap FSM.
//   Optional feature macro: VECTORED_INTR_EN (vectored mtvec mode).
// Ports
//   clk_i, rst_i : clock, asynchronous active-high reset
//   intr_i       : external interrupt request (level)
//   mret_i       : MRET retiring (1-cycle pulse)
//   pc_i         : PC saved to mepc on interrupt entry
//   bus          : pipe_* request/response + stall, csr_* CSR file port
//   redirect_o   : PC redirect pulse, flush_o alongside, target_o the new PC
module csr_trap_ctrl #(
    parameter int            DW        = 32,
    parameter int            ADDRW     = 12,
    parameter logic [DW-1:0] CAUSE_EXT = 32'h8000_000B
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              intr_i,
    input  logic              mret_i,
    input  logic [DW-1:0]     pc_i,
    csr_trap_ctrl_if.slave    bus,
    output logic              redirect_o,
    output logic              flush_o,
    output logic [DW-1:0]     target_o
);
    localparam logic [ADDRW-1:0] A_MSTATUS = ADDRW'(12'h300);
    localparam logic [ADDRW-1:0] A_MIE     = ADDRW'(12'h304);
    localparam logic [ADDRW-1:0] A_MTVEC   = ADDRW'(12'h305);
    localparam logic [ADDRW-1:0] A_MEPC    = ADDRW'(12'h341);
    localparam logic [ADDRW-1:0] A_MCAUSE  = ADDRW'(12'h342);

    typedef enum logic [3:0] {
        IDLE, E_RD_ST, E_WR_EPC, E_WR_CAUSE, E_WR_ST, E_RD_TVEC,
        M_RD_ST, M_WR_ST, M_RD_EPC, REDIR
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  pc_q, pc_d;
    logic [DW-1:0]  st_q, st_d;      // mstatus word read at the start of a sequence
    logic [DW-1:0]  tgt_q, tgt_d;
    logic           redirect_q, redirect_d;
    logic           mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d;

    logic             csr_we, csr_re;
    logic [ADDRW-1:0] csr_addr;
    logic [DW-1:0]    csr_wdata;

    logic          pipe_req;
    logic          take_int;
    logic [DW-1:0] st_entry, st_mret, tvec_base, tvec_tgt;

    assign pipe_req = bus.pipe_we | bus.pipe_re;
    assign take_int = intr_i & mie_q & meie_q;

    // Entry: MPIE <= MIE, MIE <= 0. Return: MIE <= MPIE, MPIE <= 1.
    always_comb begin
        st_entry    = st_q;
        st_entry[7] = st_q[3];
        st_entry[3] = 1'b0;
        st_mret     = st_q;
        st_mret[3]  = st_q[7];
        st_mret[7]  = 1'b1;
    end

    assign tvec_base = bus.csr_rdata & ~DW'(3);
`ifdef VECTORED_INTR_EN
    assign tvec_tgt = (bus.csr_rdata[1:0] == 2'b01)
                    ? tvec_base + (DW'(CAUSE_EXT[4:0]) << 2)
                    : tvec_base;
`else
    assign tvec_tgt = tvec_base;
`endif

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        st_d           = st_q;
        tgt_d          = tgt_q;
        csr_we         = 1'b0;
        csr_re         = 1'b0;
        csr_addr       = '0;
        csr_wdata      = '0;
        bus.stall      = pipe_req;
        bus.pipe_rdata = '0;
        case (state_q)
            IDLE: begin
                if (mret_i) begin
                    state_d = M_RD_ST;
                end else if (take_int) begin
                    state_d = E_RD_ST;
                    pc_d    = pc_i;
                end else begin
                    // No trap starting: pipeline owns the CSR port.
                    bus.stall      = 1'b0;
                    csr_we         = bus.pipe_we;
                    csr_re         = bus.pipe_re;
                    csr_addr       = bus.pipe_addr;
                    csr_wdata      = bus.pipe_wdata;
                    bus.pipe_rdata = bus.csr_rdata;
                end
            end
            E_RD_ST: begin
                csr_re   = 1'b1;
                csr_addr = A_MSTATUS;
                st_d     = bus.csr_rdata;
                state_d  = E_WR_EPC;
            end
            E_WR_EPC: begin
                csr_we    = 1'b1;
                csr_addr  = A_MEPC;
                csr_wdata = pc_q;
                state_d   = E_WR_CAUSE;
            end
            E_WR_CAUSE: begin
                csr_we    = 1'b1;
                csr_addr  = A_MCAUSE;
                csr_wdata = CAUSE_EXT;
                state_d   = E_WR_ST;
            end
            E_WR_ST: begin
                csr_we    = 1'b1;
                csr_addr  = A_MSTATUS;
                csr_wdata = st_entry;
                state_d   = E_RD_TVEC;
            end
            E_RD_TVEC: begin
                csr_re   = 1'b1;
                csr_addr = A_MTVEC;
                tgt_d    = tvec_tgt;
                state_d  = REDIR;
            end
            M_RD_ST: begin
                csr_re   = 1'b1;
                csr_addr = A_MSTATUS;
                st_d     = bus.csr_rdata;
                state_d  = M_WR_ST;
            end
            M_WR_ST: begin
                csr_we    = 1'b1;
                csr_addr  = A_MSTATUS;
                csr_wdata = st_mret;
                state_d   = M_RD_EPC;
            end
            M_RD_EPC: begin
                csr_re   = 1'b1;
                csr_addr = A_MEPC;
                tgt_d    = bus.csr_rdata & ~DW'(3);
                state_d  = REDIR;
            end
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shadows track every write that reaches the CSR file, whoever issued it.
    always_comb begin
        mie_d  = mie_q;
        mpie_d = mpie_q;
        meie_d = meie_q;
        if (csr_we && csr_addr == A_MSTATUS) begin
            mie_d  = csr_wdata[3];
            mpie_d = csr_wdata[7];
        end
        if (csr_we && csr_addr == A_MIE) begin
            meie_d = csr_wdata[11];
        end
    end

    assign redirect_d = (state_d == REDIR);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            st_q       <= '0;
            tgt_q      <= '0;
            redirect_q <= 1'b0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            meie_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            st_q       <= st_d;
            tgt_q      <= tgt_d;
            redirect_q <= redirect_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            meie_q     <= meie_d;
        end
    end

    assign bus.csr_we    = csr_we;
    assign bus.csr_re    = csr_re;
    assign bus.csr_addr  = csr_addr;
    assign bus.csr_wdata = csr_wdata;

    assign redirect_o = redirect_q;
    assign flush_o    = redirect_q;
    assign target_o   = redirect_q ? tgt_q : '0;
endmodule
